// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply/divide responder.
// Signed multiply uses radix-2 Booth steps and signed divide uses restoring
// steps on magnitudes. Each runs 32 iterations, then pulses done for one
// cycle with the result held in hi/lo.
// Optional feature macro: MULT_DIV_DIV_EN. When defined, the divider is built.
// When undefined, a div request completes at once with hi/lo untouched.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   start, op     : request pulse (sampled in IDLE) and opcode (01 mult, 10 div)
//   a, b          : operands (multiplicand/dividend, multiplier/divisor)
//   busy, done    : iterating flag, one-cycle completion pulse
//   div0          : divide-by-zero flag, valid with done
//   hi, lo        : product[63:32]/remainder, product[31:0]/quotient
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW      = $clog2(WIDTH);
    localparam logic [1:0]  OP_MULT = 2'b01;
    localparam logic [1:0]  OP_DIV  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DONE
`ifdef MULT_DIV_DIV_EN
        , DIV
`endif
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  count;
    logic           last_step;
    logic           accept_mult;
    logic           accept_div;
    logic           accept_div0;

    // Booth datapath: upper half carries one guard bit so the most negative
    // multiplicand can be subtracted without overflow.
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             qm1;
    logic [WIDTH:0]   mcand_x;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   acc_hi_n;
    logic [WIDTH-1:0] acc_lo_n;

    assign last_step = (count == CW'(WIDTH - 1));

    // Next-state and request decode.
    always_comb begin
        state_n     = state;
        accept_mult = 1'b0;
        accept_div  = 1'b0;
        accept_div0 = 1'b0;
        case (state)
            IDLE: begin
                if (start && op == OP_MULT) begin
                    accept_mult = 1'b1;
                    state_n     = MULT;
                end else if (start && op == OP_DIV) begin
`ifdef MULT_DIV_DIV_EN
                    if (b == '0) begin
                        accept_div0 = 1'b1;
                        state_n     = DONE;
                    end else begin
                        accept_div  = 1'b1;
                        state_n     = DIV;
                    end
`else
                    state_n = DONE;
`endif
                end
            end
            MULT: if (last_step) state_n = DONE;
`ifdef MULT_DIV_DIV_EN
            DIV:  if (last_step) state_n = DONE;
`endif
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // One Booth step followed by an arithmetic right shift of {acc, q_-1}.
    always_comb begin
        mcand_x   = {mcand[WIDTH-1], mcand};
        booth_sum = acc_hi;
        case ({acc_lo[0], qm1})
            2'b01:   booth_sum = acc_hi + mcand_x;
            2'b10:   booth_sum = acc_hi - mcand_x;
            default: booth_sum = acc_hi;
        endcase
        acc_hi_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        acc_lo_n = {booth_sum[0], acc_lo[WIDTH-1:1]};
    end

`ifdef MULT_DIV_DIV_EN
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] rem_n;

    // One restoring step: shift in the next dividend bit, keep the
    // difference only when it does not go negative.
    always_comb begin
        r_sh = {rem, quo[WIDTH-1]};
        diff = r_sh - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_n = diff[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = r_sh[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // Divider registers; magnitudes are taken at accept so a/b may change.
    always_ff @(posedge clock) begin
        if (reset) begin
            divisor <= '0;
            quo     <= '0;
            rem     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (accept_div) begin
            divisor <= b[WIDTH-1] ? -b : b;
            quo     <= a[WIDTH-1] ? -a : a;
            rem     <= '0;
            neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r   <= a[WIDTH-1];
        end else if (state == DIV) begin
            quo <= quo_n;
            rem <= rem_n;
        end
    end
`endif

    // Shared iteration counter, multiplier registers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            qm1    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            busy <= (state_n == MULT)
`ifdef MULT_DIV_DIV_EN
                    || (state_n == DIV)
`endif
                    ;
            done <= (state_n == DONE);
            div0 <= accept_div0;

            if (accept_mult || accept_div) begin
                count <= '0;
            end else if (state == MULT
`ifdef MULT_DIV_DIV_EN
                         || state == DIV
`endif
                         ) begin
                count <= count + CW'(1);
            end

            if (accept_mult) begin
                mcand  <= a;
                acc_hi <= '0;
                acc_lo <= b;
                qm1    <= 1'b0;
            end else if (state == MULT) begin
                acc_hi <= acc_hi_n;
                acc_lo <= acc_lo_n;
                qm1    <= acc_lo[0];
                if (last_step) begin
                    hi <= acc_hi_n[WIDTH-1:0];
                    lo <= acc_lo_n;
                end
            end
`ifdef MULT_DIV_DIV_EN
            else if (state == DIV && last_step) begin
                // Quotient sign follows the operand signs; remainder follows the dividend.
                lo <= neg_q ? -quo_n : quo_n;
                hi <= neg_r ? -rem_n : rem_n;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit with hand-computed expectations.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    int          lat;
    int          bcnt;
    logic        bdone;
    logic        dz;
    logic [31:0] rh;
    logic [31:0] rl;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .div0(div0),
        .hi(hi), .lo(lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one request and wait (bounded) for done; returns latency from
    // the start cycle, busy-cycle count and outputs seen in the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; op = 2'b00; a = $urandom; b = $urandom;
        lat = 1; bcnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            tick();
            lat++;
        end
        bdone = busy; dz = div0; rh = hi; rl = lo;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        tick(); tick();
        n_cmp++; if ({busy, done, div0} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, div0}); end
        n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mult();
        run_op(2'b01, 32'd7, 32'hFFFF_FFFD);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL mult_latency: got %0d want 33", lat); end
        n_cmp++; if (bcnt !== 32) begin n_bad++; $display("FAIL mult_busy_cycles: got %0d want 32", bcnt); end
        n_cmp++; if (bdone !== 1'b0 || dz !== 1'b0) begin n_bad++; $display("FAIL mult_busy_div0_at_done: got %b%b want 00", bdone, dz); end
        n_cmp++; if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_bad++; $display("FAIL mult_7_m3: got %h want ffffffffffffffeb", {rh, rl}); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_one_cycle: got %b want 0", done); end
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000);
        n_cmp++; if ({rh, rl} !== 64'h4000_0000_0000_0000) begin n_bad++; $display("FAIL mult_min_min: got %h want 4000000000000000", {rh, rl}); end
        tick();
        run_op(2'b01, 32'd12345, 32'd6789);
        n_cmp++; if ({rh, rl} !== 64'h0000_0000_04FE_D79D) begin n_bad++; $display("FAIL mult_pos_pos: got %h want 0000000004fed79d", {rh, rl}); end
        tick();
    endtask

`ifdef MULT_DIV_DIV_EN
    task automatic test_div();
        run_op(2'b10, 32'd100, 32'd7);
        n_cmp++; if (lat !== 33 || bcnt !== 32) begin n_bad++; $display("FAIL div_timing: got lat %0d busy %0d want 33/32", lat, bcnt); end
        n_cmp++; if (rl !== 32'd14 || rh !== 32'd2 || dz !== 1'b0) begin n_bad++; $display("FAIL div_100_7: got lo %h hi %h div0 %b want 0000000e/00000002/0", rl, rh, dz); end
        tick();
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        n_cmp++; if (rl !== 32'hFFFF_FFFD || rh !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_m7_2: got lo %h hi %h want fffffffd/ffffffff", rl, rh); end
        tick();
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        n_cmp++; if (rl !== 32'h8000_0000 || rh !== 32'h0 || dz !== 1'b0) begin n_bad++; $display("FAIL div_overflow: got lo %h hi %h div0 %b want 80000000/00000000/0", rl, rh, dz); end
        tick();
        // Preload hi/lo with -21, then divide by zero.
        run_op(2'b01, 32'd7, 32'hFFFF_FFFD);
        tick();
        run_op(2'b10, 32'd55, 32'd0);
        n_cmp++; if (lat !== 1 || bcnt !== 0 || dz !== 1'b1) begin n_bad++; $display("FAIL div0_flag: got lat %0d busy %0d div0 %b want 1/0/1", lat, bcnt, dz); end
        n_cmp++; if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_bad++; $display("FAIL div0_hilo_kept: got %h want ffffffffffffffeb", {rh, rl}); end
        tick();
        n_cmp++; if (div0 !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL div0_clears: got div0 %b done %b want 0/0", div0, done); end
    endtask
`else
    task automatic test_div_disabled();
        run_op(2'b01, 32'd7, 32'hFFFF_FFFD);
        tick();
        run_op(2'b10, 32'd100, 32'd7);
        n_cmp++; if (lat !== 1 || bcnt !== 0) begin n_bad++; $display("FAIL div_off_timing: got lat %0d busy %0d want 1/0", lat, bcnt); end
        n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL div_off_div0: got %b want 0", dz); end
        n_cmp++; if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_bad++; $display("FAIL div_off_hilo_kept: got %h want ffffffffffffffeb", {rh, rl}); end
        tick();
    endtask
`endif

    task automatic test_ignored_ops();
        logic saw;
        saw = 1'b0;
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
        tick();
        op = 2'b11;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (busy === 1'b1 || done === 1'b1) saw = 1'b1;
            tick();
        end
        n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL ignored_op: got activity %b want 0", saw); end
    endtask

    task automatic test_start_during_busy();
        int c;
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
        tick();
        start = 1'b0;
        c = 1;
        while (done !== 1'b1 && c < 40) begin
            if (c == 4) begin start = 1'b1; a = 32'd100; b = 32'd100; end
            else        begin start = 1'b0; end
            tick();
            c++;
        end
        start = 1'b0;
        n_cmp++; if (c !== 33 || lo !== 32'd15 || hi !== 32'd0) begin n_bad++; $display("FAIL start_in_busy: got lat %0d hi %h lo %h want 33/0/f", c, hi, lo); end
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL no_queue: got busy %b done %b want 0/0", busy, done); end
    endtask

    task automatic test_reset_midflight();
        start = 1'b1; op = 2'b01; a = 32'd7; b = 32'd9;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        n_cmp++; if ({busy, done, div0} !== 3'b000 || {hi, lo} !== 64'h0) begin n_bad++; $display("FAIL reset_midflight: got flags %b hilo %h want 000/0", {busy, done, div0}, {hi, lo}); end
        reset = 1'b0;
        tick();
        run_op(2'b01, 32'd6, 32'd7);
        n_cmp++; if (lat !== 33 || rl !== 32'd42 || rh !== 32'd0) begin n_bad++; $display("FAIL after_reset: got lat %0d hi %h lo %h want 33/0/2a", lat, rh, rl); end
        tick();
    endtask

    task automatic test_back_to_back();
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_cmp++; if ({rh, rl} !== 64'h1) begin n_bad++; $display("FAIL b2b_first: got %h want 1", {rh, rl}); end
        tick();
        run_op(2'b01, 32'd11, 32'hFFFF_FFFE);
        n_cmp++; if (lat !== 33 || {rh, rl} !== 64'hFFFF_FFFF_FFFF_FFEA) begin n_bad++; $display("FAIL b2b_second: got lat %0d val %h want 33/ffffffffffffffea", lat, {rh, rl}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_mult();
`ifdef MULT_DIV_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_ignored_ops();
        test_start_during_busy();
        test_reset_midflight();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
